// File: rtl/io_dma_seq_pkg.sv
// Shared definitions for the UART-to-memory DMA write sequencer: FSM states,
// word width, address step and window validation.
package io_dma_seq_pkg;

  localparam int unsigned IO_WORD_W = 32;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_REQ  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // A window is rejected when either bound is not word aligned or it is inverted.
  function automatic logic window_bad(input logic [31:0] first, input logic [31:0] last);
    return (first[1:0] != 2'b00) || (last[1:0] != 2'b00) || (first > last);
  endfunction

endpackage

// File: rtl/io_dma_seq_fifo.sv
// Synchronous word FIFO with flush; full/empty decode from a registered count.
module io_dma_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_dma_seq.sv
// DMA write sequencer: buffers source words and writes them as Wishbone-classic
// single beats across [addr_first..addr_end]. Optional beat timeout: IO_DMA_TIMEOUT_EN.
module io_dma_seq
  import io_dma_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [31:0] cfg_addr_first,
  input  logic [31:0] cfg_addr_end,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        dma_cyc_o,
  output logic        dma_stb_o,
  input  logic        dma_ack_i,
  output logic        dma_we_o,
  output logic [31:0] dma_addr_o,
  output logic [31:0] dma_data_o,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] st_words
);

  state_t state_q, state_d;

  logic [31:0]          addr_q;
  logic [31:0]          end_q;
  logic [31:0]          words_q;
  logic                 done_q;
  logic                 err_q;
  logic                 in_xfer;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IO_WORD_W-1:0] fifo_head;
  logic                 start_ok;
  logic                 start_bad;
  logic                 beat_ack;
  logic                 tmo_hit;
  logic                 tmo_err;

  // Source handshake: a word moves on any edge where wr_valid && wr_ready.
  assign in_xfer   = (state_q == ST_ARM) || (state_q == ST_REQ);
  assign wr_ready  = !fifo_full && in_xfer;
  assign fifo_push = wr_valid && wr_ready;

  io_dma_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IO_WORD_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IO_DMA_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Held at zero outside REQ, so every beat starts its wait from zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q != ST_REQ) tmo_cnt <= '0;
    else if (!dma_ack_i)              tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = (state_q == ST_REQ) && (tmo_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    beat_ack   = 1'b0;
    tmo_err    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (cfg_start) begin
          fifo_flush = 1'b1;
          if (window_bad(cfg_addr_first, cfg_addr_end)) begin
            start_bad = 1'b1;
            state_d   = ST_ERR;
          end else begin
            start_ok = 1'b1;
            state_d  = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (cfg_abort) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (!fifo_empty) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Abort outranks a simultaneous ack: the beat is dropped, not counted.
        if (cfg_abort) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (dma_ack_i) begin
          fifo_pop = 1'b1;
          beat_ack = 1'b1;
          state_d  = (addr_q == end_q) ? ST_DONE : ST_ARM;
        end else if (tmo_hit) begin
          fifo_flush = 1'b1;
          tmo_err    = 1'b1;
          state_d    = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok || start_bad) begin
        addr_q  <= cfg_addr_first;
        end_q   <= cfg_addr_end;
        words_q <= '0;
        done_q  <= 1'b0;
        err_q   <= start_bad;
      end
      if (beat_ack) begin
        words_q <= words_q + 32'd1;
        addr_q  <= addr_q + ADDR_STEP;
        if (state_d == ST_DONE) done_q <= 1'b1;
      end
      if (tmo_err) err_q <= 1'b1;
    end
  end

  // Bus outputs are decoded from state only, so they drop the cycle after any exit from REQ.
  assign dma_cyc_o  = (state_q == ST_REQ);
  assign dma_stb_o  = dma_cyc_o;
  assign dma_we_o   = dma_cyc_o;
  assign dma_addr_o = dma_cyc_o ? addr_q : '0;
  assign dma_data_o = dma_cyc_o ? fifo_head : '0;

  assign st_busy  = in_xfer;
  assign st_done  = done_q;
  assign st_err   = err_q;
  assign st_words = words_q;

endmodule

// File: tb/tb_io_dma_seq.sv
// Directed self-checking bench for io_dma_seq (timeout scenario follows IO_DMA_TIMEOUT_EN).
module tb_io_dma_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_addr_first = '0;
  logic [31:0] cfg_addr_end = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        dma_cyc_o;
  logic        dma_stb_o;
  logic        dma_ack_i = 1'b0;
  logic        dma_we_o;
  logic [31:0] dma_addr_o;
  logic [31:0] dma_data_o;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic [31:0] st_words;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  io_dma_seq #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_addr_first (cfg_addr_first),
    .cfg_addr_end   (cfg_addr_end),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .dma_cyc_o      (dma_cyc_o),
    .dma_stb_o      (dma_stb_o),
    .dma_ack_i      (dma_ack_i),
    .dma_we_o       (dma_we_o),
    .dma_addr_o     (dma_addr_o),
    .dma_data_o     (dma_data_o),
    .st_busy        (st_busy),
    .st_done        (st_done),
    .st_err         (st_err),
    .st_words       (st_words)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic start(input logic [31:0] first, input logic [31:0] last);
    cfg_addr_first = first;
    cfg_addr_end   = last;
    cfg_start      = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    int n = 0;
    logic acc = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!acc && n < 20) begin
      acc = wr_ready;
      tick();
      n++;
    end
    wr_valid = 1'b0;
    check("push_accept", acc, 1);
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!dma_stb_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, dma_stb_o, 1);
  endtask

  // Pushes n_new words seeded at seed while acking every strobe; each beat is
  // scored against the expected queue and the running expected address.
  task automatic stream(input int n_new, input logic [31:0] seed, input int n_beats);
    int   pushed = 0;
    int   beats = 0;
    int   cyc = 0;
    logic acc;
    logic ack;
    while ((pushed < n_new || beats < n_beats) && cyc < 300) begin
      wr_valid  = (pushed < n_new);
      wr_data   = seed + 32'(pushed);
      ack       = dma_stb_o;
      dma_ack_i = ack;
      if (ack) begin
        check("beat_addr", dma_addr_o, exp_addr);
        check("beat_we", dma_we_o, 1);
        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
        else check("beat_data", dma_data_o, exp_q[0]);
      end
      acc = wr_valid && wr_ready;
      tick();
      if (acc) begin
        exp_q.push_back(wr_data);
        pushed++;
      end
      if (ack) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_addr = exp_addr + 32'd4;
        beats++;
        check("beat_gap", dma_cyc_o, 0);
      end
      cyc++;
    end
    wr_valid  = 1'b0;
    dma_ack_i = 1'b0;
    check("stream_budget", (cyc < 300) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    tick();
    tick();
    sys_rst = 1'b0;

    // Reset state
    check("rst_cyc", dma_cyc_o, 0);
    check("rst_stb", dma_stb_o, 0);
    check("rst_we", dma_we_o, 0);
    check("rst_addr", dma_addr_o, 0);
    check("rst_data", dma_data_o, 0);
    check("rst_ready", wr_ready, 0);
    check("rst_busy", st_busy, 0);
    check("rst_status", {st_done, st_err}, 0);
    check("rst_words", st_words, 0);

    // Idle words are refused
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD;
    tick();
    check("idle_ready", wr_ready, 0);
    wr_valid = 1'b0;

    // 1: four-word window, strobe two cycles after the first push
    start(32'h100, 32'h10C);
    check("t1_busy", st_busy, 1);
    check("t1_ready", wr_ready, 1);
    check("t1_cyc_idle", dma_cyc_o, 0);
    exp_addr = 32'h100;
    wr_valid = 1'b1;
    wr_data  = 32'hA0;
    tick();
    wr_valid = 1'b0;
    exp_q.push_back(32'hA0);
    check("t1_lat_n1", dma_stb_o, 0);
    tick();
    check("t1_lat_n2", dma_stb_o, 1);
    stream(3, 32'hA1, 4);
    check("t1_done", st_done, 1);
    check("t1_words", st_words, 4);
    check("t1_busy_end", st_busy, 0);
    check("t1_ready_end", wr_ready, 0);
    check("t1_err", st_err, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: inverted and misaligned windows
    start(32'h104, 32'h100);
    check("t2_err_inv", st_err, 1);
    check("t2_done_clr", st_done, 0);
    check("t2_busy", st_busy, 0);
    check("t2_ready", wr_ready, 0);
    tick();
    tick();
    check("t2_no_cyc", dma_cyc_o, 0);
    start(32'h102, 32'h10C);
    check("t2_err_mis", st_err, 1);
    check("t2_words", st_words, 0);
    check("t2_no_cyc2", dma_cyc_o, 0);

    // 3: ack held off, FIFO fills and back-pressures
    start(32'h200, 32'h214);
    check("t3_err_clr", st_err, 0);
    exp_addr = 32'h200;
    for (int i = 0; i < 4; i++) push_word(32'h300 + 32'(i));
    check("t3_full_ready", wr_ready, 0);
    check("t3_stb_held", dma_stb_o, 1);
    check("t3_head", dma_data_o, 32'h300);
    wr_valid = 1'b1;
    wr_data  = 32'h304;
    tick();
    tick();
    check("t3_still_full", wr_ready, 0);
    check("t3_addr_stable", dma_addr_o, 32'h200);
    wr_valid = 1'b0;
    stream(2, 32'h304, 6);
    check("t3_words", st_words, 6);
    check("t3_done", st_done, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: abort together with ack
    start(32'h400, 32'h40C);
    push_word(32'h500);
    push_word(32'h501);
    wait_stb("t4_stb");
    cfg_abort = 1'b1;
    dma_ack_i = 1'b1;
    tick();
    cfg_abort = 1'b0;
    dma_ack_i = 1'b0;
    check("t4_cyc", dma_cyc_o, 0);
    check("t4_busy", st_busy, 0);
    check("t4_words", st_words, 0);
    check("t4_status", {st_done, st_err}, 0);
    wr_valid = 1'b1;
    wr_data  = 32'h502;
    tick();
    check("t4_ready", wr_ready, 0);
    tick();
    check("t4_cyc_later", dma_cyc_o, 0);
    wr_valid = 1'b0;
    exp_q.delete();

    // 5: beat never acked
    start(32'h800, 32'h80C);
    push_word(32'h900);
    wait_stb("t5_stb");
`ifdef IO_DMA_TIMEOUT_EN
    begin
      int n = 0;
      while (dma_cyc_o && n < 20) begin
        n++;
        tick();
      end
      check("t5_tmo_cycles", n, 8);
      check("t5_err", st_err, 1);
      check("t5_busy", st_busy, 0);
      check("t5_words", st_words, 0);
    end
`else
    begin
      int n = 0;
      while (dma_cyc_o && n < 1000) begin
        n++;
        tick();
      end
      check("t5_hold_cycles", n, 1000);
      check("t5_err", st_err, 0);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check("t5_abort_cyc", dma_cyc_o, 0);
    end
`endif
    exp_q.delete();

    // 6: reset mid-beat, then a clean run
    start(32'hA00, 32'hA0C);
    push_word(32'hB00);
    wait_stb("t6_stb");
    sys_rst = 1'b1;
    tick();
    check("t6_cyc", dma_cyc_o, 0);
    check("t6_stb", dma_stb_o, 0);
    check("t6_we", dma_we_o, 0);
    check("t6_addr", dma_addr_o, 0);
    check("t6_data", dma_data_o, 0);
    check("t6_busy", st_busy, 0);
    check("t6_status", {st_done, st_err}, 0);
    check("t6_ready", wr_ready, 0);
    sys_rst = 1'b0;
    tick();
    check("t6_quiet", dma_cyc_o, 0);
    exp_q.delete();
    start(32'hA00, 32'hA04);
    exp_addr = 32'hA00;
    stream(2, 32'hC00, 2);
    check("t6_words", st_words, 2);
    check("t6_done", st_done, 1);
    check("t6_err", st_err, 0);

    // Single-word window
    start(32'hF00, 32'hF00);
    exp_addr = 32'hF00;
    stream(1, 32'hD00, 1);
    check("t7_words", st_words, 1);
    check("t7_done", st_done, 1);
    check("t7_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
